// File: rtl/load_writeback_queue_if.sv
// Handshake bundle between the memory stage, the data bus and the register-file write port
// of the load writeback queue.
interface load_writeback_queue_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [REG_W-1:0]  req_dst;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [1:0]        req_offset;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [REG_W-1:0]  alu_dst;
  logic [DATA_W-1:0] alu_data;
  logic              wr_en;
  logic [REG_W-1:0]  wr_reg;
  logic [DATA_W-1:0] wr_word;
  logic              load_done;

  modport master (
    output req_valid, req_dst, req_size, req_signed, req_offset,
    output resp_valid, resp_data,
    output alu_valid, alu_dst, alu_data,
    input  req_ready, alu_ready, wr_en, wr_reg, wr_word, load_done
  );

  modport slave (
    input  req_valid, req_dst, req_size, req_signed, req_offset,
    input  resp_valid, resp_data,
    input  alu_valid, alu_dst, alu_data,
    output req_ready, alu_ready, wr_en, wr_reg, wr_word, load_done
  );
endinterface

// File: rtl/load_writeback_queue.sv
// Writeback stage with a FIFO of outstanding loads: aligns bus responses, merges them with
// ALU results onto one registered register-file write port, and exports a pending-load mask.
module load_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                   clk,
  input  logic                   resetn,
  load_writeback_queue_if.slave  bus,
  input  logic                   flush,
  output logic [(2**REG_W)-1:0]  busy_mask,
  output logic [$clog2(DEPTH):0] pending_cnt,
  output logic                   resp_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [REG_W-1:0]  ent_dst    [DEPTH];
  logic [1:0]        ent_size   [DEPTH];
  logic              ent_signed [DEPTH];
  logic [1:0]        ent_offset [DEPTH];
  logic              ent_killed [DEPTH];
  logic              ent_valid  [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              load_wr;
  logic              alu_acc;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_word;

  // Ready depends only on occupancy, so a full queue refuses a push even while popping.
  assign empty           = (count == '0);
  assign full            = (count == CNT_W'(DEPTH));
  assign push            = bus.req_valid && !full;
  assign pop             = bus.resp_valid && !empty;
  assign load_wr         = pop && !ent_killed[head];
  assign alu_acc         = bus.alu_valid && !load_wr;
  assign bus.req_ready   = !full;
  assign bus.alu_ready   = !load_wr;
  assign pending_cnt     = count;

  always_comb begin
    byte_sel = bus.resp_data[{ent_offset[head], 3'b000} +: 8];
    half_sel = ent_offset[head][1] ? bus.resp_data[31:16] : bus.resp_data[15:0];
    case (ent_size[head])
      2'd0:    load_word = {{(DATA_W-8){ent_signed[head] & byte_sel[7]}}, byte_sel};
      2'd1:    load_word = {{(DATA_W-16){ent_signed[head] & half_sel[15]}}, half_sel};
      default: load_word = bus.resp_data;
    endcase
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && !ent_killed[i] && ent_dst[i] != '0)
        busy_mask[ent_dst[i]] = 1'b1;
    end
  end

  // A flush marks live entries killed; a push in the same cycle lands already killed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_dst[i]    <= '0;
        ent_size[i]   <= '0;
        ent_signed[i] <= 1'b0;
        ent_offset[i] <= '0;
        ent_killed[i] <= 1'b0;
        ent_valid[i]  <= 1'b0;
      end
    end else begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_valid[i])
            ent_killed[i] <= 1'b1;
        end
      end
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      if (push) begin
        ent_dst[tail]    <= bus.req_dst;
        ent_size[tail]   <= bus.req_size;
        ent_signed[tail] <= bus.req_signed;
        ent_offset[tail] <= bus.req_offset;
        ent_killed[tail] <= flush;
        ent_valid[tail]  <= 1'b1;
        tail             <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Register 0 is never written, so both the enable and the load qualifier drop for it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.wr_en     <= 1'b0;
      bus.wr_reg    <= '0;
      bus.wr_word   <= '0;
      bus.load_done <= 1'b0;
      resp_err      <= 1'b0;
    end else begin
      bus.wr_en     <= (load_wr && ent_dst[head] != '0) || (alu_acc && bus.alu_dst != '0);
      bus.load_done <= load_wr && ent_dst[head] != '0;
      if (load_wr) begin
        bus.wr_reg  <= ent_dst[head];
        bus.wr_word <= load_word;
      end else if (alu_acc) begin
        bus.wr_reg  <= bus.alu_dst;
        bus.wr_word <= bus.alu_data;
      end
      if (bus.resp_valid && empty)
        resp_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_load_writeback_queue.sv
// Bench for load_writeback_queue: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_load_writeback_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0] dst;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] off;
    logic       killed;
  } load_t;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic [31:0] busy_mask;
  logic [2:0]  pending_cnt;
  logic        resp_err;

  load_writeback_queue_if #(.DATA_W(32), .REG_W(5)) bus ();

  load_writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .REG_W(5)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .flush       (flush),
    .busy_mask   (busy_mask),
    .pending_cnt (pending_cnt),
    .resp_err    (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  load_t       mq[$];
  int          checks   = 0;
  int          failures = 0;
  logic [4:0]  exp_reg  = '0;
  logic [31:0] exp_word = '0;
  logic        exp_err  = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelAlign(input load_t e, input logic [31:0] d);
    int unsigned v;
    if (e.size == 2'd0) begin
      v = (d >> (8 * e.off)) & 32'hFF;
      if (e.sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (e.size == 2'd1) begin
      v = (d >> ((e.off >= 2) ? 16 : 0)) & 32'hFFFF;
      if (e.sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic [31:0] modelMask();
    logic [31:0] m = '0;
    foreach (mq[i]) if (!mq[i].killed && mq[i].dst != 0) m[mq[i].dst] = 1'b1;
    return m;
  endfunction

  // One clock of stimulus: check combinational outputs before the edge, model the edge,
  // then check registered outputs shortly after it.
  task automatic applyStimulus(input logic rv, input logic [4:0] dst, input logic [1:0] sz,
                               input logic sg, input logic [1:0] off, input logic rsv,
                               input logic [31:0] rd, input logic av, input logic [4:0] ad,
                               input logic [31:0] adat, input logic fl);
    logic  exp_ready;
    logic  load_w;
    logic  e_en;
    logic  e_ld;
    load_t ne;
    @(negedge clk);
    bus.req_valid  = rv;
    bus.req_dst    = dst;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_offset = off;
    bus.resp_valid = rsv;
    bus.resp_data  = rd;
    bus.alu_valid  = av;
    bus.alu_dst    = ad;
    bus.alu_data   = adat;
    flush          = fl;
    #1;
    exp_ready = (mq.size() < DEPTH);
    load_w    = rsv && mq.size() > 0 && !mq[0].killed;
    checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    checkOutput("pending_cnt", 32'(pending_cnt), 32'(mq.size()));
    checkOutput("busy_mask", busy_mask, modelMask());
    checkOutput("alu_ready", 32'(bus.alu_ready), 32'(!load_w));
    e_en = 1'b0;
    e_ld = 1'b0;
    if (load_w) begin
      e_en     = (mq[0].dst != 0);
      e_ld     = e_en;
      exp_reg  = mq[0].dst;
      exp_word = modelAlign(mq[0], rd);
    end else if (av) begin
      e_en     = (ad != 0);
      exp_reg  = ad;
      exp_word = adat;
    end
    if (rsv && mq.size() == 0) exp_err = 1'b1;
    if (fl) foreach (mq[i]) mq[i].killed = 1'b1;
    if (rsv && mq.size() > 0) void'(mq.pop_front());
    if (rv && exp_ready) begin
      ne.dst = dst; ne.size = sz; ne.sgn = sg; ne.off = off; ne.killed = fl;
      mq.push_back(ne);
    end
    @(posedge clk);
    #1;
    checkOutput("wr_en", 32'(bus.wr_en), 32'(e_en));
    checkOutput("load_done", 32'(bus.load_done), 32'(e_ld));
    if (e_en) begin
      checkOutput("wr_reg", 32'(bus.wr_reg), 32'(exp_reg));
      checkOutput("wr_word", bus.wr_word, exp_word);
    end
    checkOutput("resp_err", 32'(resp_err), 32'(exp_err));
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkResetState();
    checkOutput("rst_wr_en", 32'(bus.wr_en), 0);
    checkOutput("rst_wr_reg", 32'(bus.wr_reg), 0);
    checkOutput("rst_wr_word", bus.wr_word, 0);
    checkOutput("rst_load_done", 32'(bus.load_done), 0);
    checkOutput("rst_pending", 32'(pending_cnt), 0);
    checkOutput("rst_busy", busy_mask, 0);
    checkOutput("rst_err", 32'(resp_err), 0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 1);
    checkOutput("rst_alu_ready", 32'(bus.alu_ready), 1);
  endtask

  initial begin
    resetn = 1'b0;
    flush  = 1'b0;
    bus.req_valid = 0; bus.req_dst = 0; bus.req_size = 0; bus.req_signed = 0; bus.req_offset = 0;
    bus.resp_valid = 0; bus.resp_data = 0; bus.alu_valid = 0; bus.alu_dst = 0; bus.alu_data = 0;
    #22;
    checkResetState();
    @(negedge clk);
    resetn = 1'b1;

    // LB signed, offset 2
    applyStimulus(1, 3, 0, 1, 2, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h1280_3456, 0, 0, 0, 0);
    idle();

    // Fill the queue, try a refused push with a coincident pop, then drain
    applyStimulus(1, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5, 1, 0, 2, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 8, 2, 0, 0, 1, 32'h8899_AABB, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h8899_AABB, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h8899_AABB, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h8899_AABB, 0, 0, 0, 0);
    idle();

    // ALU result colliding with a live load response
    applyStimulus(1, 10, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 1, 9, 32'h55, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h55, 0);
    idle();

    // Flush two queued loads, then consume their responses
    applyStimulus(1, 11, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 12, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h1111_2222, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h3333_4444, 0, 0, 0, 0);
    idle();

    // Register 0 destinations
    applyStimulus(1, 0, 2, 0, 0, 0, 0, 1, 0, 32'h77, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
    idle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 99) < 45), $urandom(),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                    1'($urandom_range(0, 15) == 0));
    end

    // Stray response with an empty queue is sticky
    while (mq.size() > 0) applyStimulus(0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hABCD_0123, 0, 0, 0, 0);
    idle();
    idle();

    // Asynchronous reset with loads in flight
    applyStimulus(1, 13, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 14, 0, 1, 3, 0, 0, 1, 15, 32'h99, 0);
    @(negedge clk);
    bus.req_valid = 0; bus.resp_valid = 0; bus.alu_valid = 0; flush = 0;
    #2;
    resetn = 1'b0;
    #1;
    checkResetState();
    mq.delete();
    exp_err = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    idle();
    applyStimulus(1, 20, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h8000_1234, 0, 0, 0, 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_writeback_queue.md
# load_writeback_queue

Parametrised writeback stage for the five-stage MIPS core that supports multiple outstanding loads. It sits between the memory stage and the register file. It tracks up to DEPTH loads in flight on the data bus in a FIFO, captures each bus response, aligns and extends the loaded byte, halfword or word, and merges load results with ALU/link results onto a single registered register-file write port. It also exports a per-register pending-load mask so hazard logic can stall consumers of in-flight loads.

## Interface
- DEPTH, 4, maximum outstanding loads (power of two, ≥2)
- DATA_W, 32, data/register width (fixed at 32 for byte lanes; parameter exists for checking)
- REG_W, 5, register index width
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  memory stage issues a load whose address the bus accepted this cycle
- req_ready  out  1  queue can accept a load (count < DEPTH)
- req_dst  in  REG_W  destination register
- req_size  in  2  0=byte, 1=half, 2=word (3 illegal, treated as word)
- req_signed  in  1  sign-extend (LB/LH) vs zero-extend (LBU/LHU)
- req_offset  in  2  address bits [1:0]
- resp_valid  in  1  bus data_ok, one pulse per accepted load, in order
- resp_data  in  DATA_W  bus read data, full word
- alu_valid  in  1  non-load result to write back
- alu_ready  out  1  ALU result accepted this cycle
- alu_dst  in  REG_W
- alu_data  in  DATA_W
- flush  in  1  kill all queued loads (exception/redirect)
- wr_en  out  1  register-file write enable (registered)
- wr_reg  out  REG_W
- wr_word  out  DATA_W
- load_done  out  1  wr_en this cycle carries load data (forwarding qualifier)
- busy_mask  out  2^REG_W  bit r set when a live queued load targets register r
- pending_cnt  out  $clog2(DEPTH)+1  entries in queue
- resp_err  out  1  sticky: resp_valid seen with empty queue

## Operation
- FIFO entry fields: dst, size, signed, offset, killed. Push on req_valid && req_ready; pop on resp_valid with a non-empty queue.
- Alignment of resp_data using the head entry:
  - byte: lane = offset, bits [8*offset+7 : 8*offset]
  - half: offset[1] selects [15:0] or [31:16]; offset[0] ignored
  - word: offset ignored
  - Extension follows req_signed; word ignores it.
- Write-port arbitration: a load result (pop of a non-killed entry) takes priority. alu_ready = !(resp_valid && queue non-empty && !head.killed). alu_valid && alu_ready registers the ALU write.
- Killed entries pop normally and write nothing. alu_ready stays 1 that cycle.
- Any write with destination 0 has wr_en forced to 0. load_done follows the same rule.
- flush sets killed on every current entry. A request accepted in the flush cycle is also enqueued killed. The bus responses for killed entries are still consumed.
- busy_mask = OR over live (non-killed) entries of onehot(dst), excluding register 0. It is combinational from queue state.
- resp_err sets on resp_valid with an empty queue (a same-cycle push does not count). It clears only on reset. The stray response is dropped.

## Timing
- Reset (asynchronous, resetn=0) clears:
  - wr_en=0, wr_reg=0, wr_word=0, load_done=0
  - pending_cnt=0, busy_mask=0, resp_err=0
  - all entries invalid
  - req_ready=1; alu_ready=1 after reset
- Reset mid-operation discards all in-flight loads.
- Load latency: resp_valid in cycle T → wr_en/wr_word valid in T+1. ALU latency: accept in T → write in T+1.
- req_ready depends only on count, not on a same-cycle pop. When full, a push is refused even if a pop happens the same cycle.
- Simultaneous push and pop (not full): count unchanged, head advances.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- busy_mask bit clears in the cycle after the pop edge, the same cycle wr_en is asserted. Consumers may then take the forwarded value.

## Test plan
- Reset, then LB dst=3 offset=2 signed, resp_data=0x12_80_34_56 → T+1: wr_en=1, wr_reg=3, wr_word=0xFFFFFF80, load_done=1; busy_mask[3] 1→0.
- Four loads (DEPTH=4) with dst 4..7 (LW, LHU off=2, LBU off=1, LH off=0), resp_data=0x8899AABB each → req_ready=0 after the 4th; in-order writes 0x8899AABB, 0x00008899, 0x000000AA, 0xFFFFAABB.
- alu_valid (dst=9, 0x55) coincident with a live resp_valid → alu_ready=0 that cycle, load written first; ALU write one cycle later.
- Two loads queued, flush, then two resp_valid → no wr_en, busy_mask=0, pending_cnt returns 0, alu_ready=1 throughout.
- Load dst=0 and ALU dst=0 → wr_en stays 0; busy_mask never sets.
- resp_valid with an empty queue → resp_err=1 and stays 1; no write. Also assert resetn mid-queue and check all outputs return to zero asynchronously.
